// File: rtl/fetch_data_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// The abort path returns an all-zero word, which fetch decodes as a NOP.
package fetch_data_mem_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam int unsigned ABORT_DATA = 0;
endpackage

// File: rtl/arb_req_slot.sv
// One request slot: a pending bit plus the request fields captured on a start pulse.
// Starts are dropped while the slot is already pending or its access is in service.
module arb_req_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_in_service,
  input  logic         i_clear,
  input  logic [W-1:0] i_fields,
  output logic         o_pending,
  output logic [W-1:0] o_fields
);
  logic         r_pending;
  logic [W-1:0] r_fields;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_fields  <= '0;
    end else if (i_start && !r_pending && !i_in_service) begin
      r_pending <= 1'b1;
      r_fields  <= i_fields;
    end else if (i_clear) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_fields  = r_fields;
endmodule

// File: rtl/fetch_data_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data has priority, but fetch is forced after STARVE_LIMIT back-to-back data grants.
module fetch_data_mem_arbiter
  import fetch_data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_start_read,
  input  logic [ADDR_W-1:0] if_address,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_read_data,
  input  logic              dm_start,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_address,
  input  logic [DATA_W-1:0] dm_write_data,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_read_data,
  output logic              mem_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner_data,
  output logic              bus_error
);
  localparam int DM_W = 1 + ADDR_W + DATA_W;

  state_t              r_state, w_next;
  logic                w_if_pend, w_dm_pend, w_busy, w_grant, w_grant_dm, w_timeout, w_finish;
  logic [ADDR_W-1:0]   w_if_addr, w_dm_addr;
  logic [DM_W-1:0]     w_dm_fields;
  logic                w_dm_we;
  logic [DATA_W-1:0]   w_dm_wdata, w_rdata;
  logic                r_owner, r_we, r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_if_rdata, r_dm_rdata;
  logic [7:0]          r_to_cnt, r_starve;

  assign w_busy = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

  arb_req_slot #(.W(ADDR_W)) u_if_slot (
    .clk, .rst,
    .i_start(if_start_read),
    .i_in_service(w_busy && (r_owner == OWNER_IF)),
    .i_clear((r_state == ST_ISSUE) && (r_owner == OWNER_IF)),
    .i_fields(if_address),
    .o_pending(w_if_pend),
    .o_fields(w_if_addr)
  );

  arb_req_slot #(.W(DM_W)) u_dm_slot (
    .clk, .rst,
    .i_start(dm_start),
    .i_in_service(w_busy && (r_owner == OWNER_DM)),
    .i_clear((r_state == ST_ISSUE) && (r_owner == OWNER_DM)),
    .i_fields({dm_we, dm_address, dm_write_data}),
    .o_pending(w_dm_pend),
    .o_fields(w_dm_fields)
  );

  assign {w_dm_we, w_dm_addr, w_dm_wdata} = w_dm_fields;

  assign w_grant    = (r_state == ST_IDLE) && (w_if_pend || w_dm_pend);
  assign w_grant_dm = w_dm_pend && !(w_if_pend && (r_starve == 8'(STARVE_LIMIT)));
  // Counter holds (WAIT cycles elapsed - 1), so abort lands on the TIMEOUT-th WAIT cycle.
  assign w_timeout  = (TIMEOUT != 0) && (r_to_cnt == 8'(TIMEOUT - 1));
  assign w_finish   = (r_state == ST_WAIT) && (mem_ready || w_timeout);
  assign w_rdata    = mem_ready ? mem_read_data : DATA_W'(ABORT_DATA);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_start = 1'b0;
    busy      = w_busy;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    bus_error = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_if_pend || w_dm_pend) w_next = ST_ISSUE;
      ST_ISSUE: begin
        mem_start = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT:  if (mem_ready || w_timeout) w_next = ST_DONE;
      ST_DONE: begin
        if_ready  = (r_owner == OWNER_IF);
        dm_ready  = (r_owner == OWNER_DM);
        bus_error = r_err;
        w_next    = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWNER_IF;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_to_cnt   <= '0;
      r_starve   <= '0;
    end else begin
      if (w_grant) begin
        r_owner  <= w_grant_dm;
        r_addr   <= w_grant_dm ? w_dm_addr : w_if_addr;
        r_we     <= w_grant_dm && w_dm_we;
        r_wdata  <= w_grant_dm ? w_dm_wdata : '0;
        r_starve <= (w_grant_dm && w_if_pend) ?
                    ((r_starve == 8'(STARVE_LIMIT)) ? r_starve : r_starve + 8'd1) : '0;
      end else if (!w_if_pend) begin
        r_starve <= '0;
      end

      if (r_state == ST_ISSUE)     r_to_cnt <= '0;
      else if (r_state == ST_WAIT) r_to_cnt <= r_to_cnt + 8'd1;

      if (w_finish) begin
        r_err <= !mem_ready;
        if (r_owner == OWNER_IF) r_if_rdata <= w_rdata;
        else if (!r_we)          r_dm_rdata <= w_rdata;
      end
    end
  end

  assign owner_data     = r_owner;
  assign mem_we         = r_we;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign if_read_data   = r_if_rdata;
  assign dm_read_data   = r_dm_rdata;
endmodule

// File: tb/tb_fetch_data_mem_arbiter.sv
// Randomized and directed bench for fetch_data_mem_arbiter against a timeline-based reference model.
module tb_fetch_data_mem_arbiter;
  localparam int AW = 32, DW = 32, SL = 4, TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_start_read = 1'b0;
  logic [AW-1:0] if_address = '0;
  logic          if_ready;
  logic [DW-1:0] if_read_data;
  logic          dm_start = 1'b0, dm_we = 1'b0;
  logic [AW-1:0] dm_address = '0;
  logic [DW-1:0] dm_write_data = '0;
  logic          dm_ready;
  logic [DW-1:0] dm_read_data;
  logic          mem_start, mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data = '0;
  logic          mem_ready = 1'b0;
  logic          busy, owner_data, bus_error;

  always #5 clk = ~clk;

  fetch_data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_start_read(if_start_read), .if_address(if_address),
    .if_ready(if_ready), .if_read_data(if_read_data),
    .dm_start(dm_start), .dm_we(dm_we), .dm_address(dm_address), .dm_write_data(dm_write_data),
    .dm_ready(dm_ready), .dm_read_data(dm_read_data),
    .mem_start(mem_start), .mem_we(mem_we), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .busy(busy), .owner_data(owner_data), .bus_error(bus_error)
  );

  int checks = 0, failures = 0;
  int c = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  // Reference model: each access is a timeline (issue cycle, done cycle) rather than a state machine.
  bit            m_pif, m_pdm, m_dmwe, m_act, m_own, m_we, m_err;
  logic [AW-1:0] m_ifa, m_dma, m_addr;
  logic [DW-1:0] m_dmwd, m_wd, m_ifrd, m_dmrd;
  int            m_ti, m_td, m_starve;

  function automatic bit in_svc(input int cy);
    return m_act && (cy >= m_ti) && (m_td < 0 || cy < m_td);
  endfunction

  task automatic model_reset();
    m_pif = 0; m_pdm = 0; m_dmwe = 0; m_act = 0; m_own = 0; m_we = 0; m_err = 0;
    m_ifa = '0; m_dma = '0; m_addr = '0; m_dmwd = '0; m_wd = '0; m_ifrd = '0; m_dmrd = '0;
    m_ti = 0; m_td = -1; m_starve = 0;
  endtask

  task automatic model_step();
    bit opif, opdm, svc, gdm;
    logic [DW-1:0] d;
    if (rst) begin model_reset(); return; end
    opif = m_pif; opdm = m_pdm; svc = in_svc(c);
    if (m_act && c > m_ti && m_td < 0 && (mem_ready || (c - m_ti) == TO)) begin
      m_td  = c + 1;
      m_err = !mem_ready;
      d     = mem_ready ? mem_read_data : '0;
      if (!m_own) m_ifrd = d;
      else if (!m_we) m_dmrd = d;
    end
    if (if_start_read && !opif && !(svc && !m_own)) begin m_pif = 1; m_ifa = if_address; end
    if (dm_start && !opdm && !(svc && m_own)) begin
      m_pdm = 1; m_dmwe = dm_we; m_dma = dm_address; m_dmwd = dm_write_data;
    end
    if ((!m_act || (m_td >= 0 && c > m_td)) && (opif || opdm)) begin
      gdm = opdm && !(opif && m_starve == SL);
      m_starve = (gdm && opif) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
      m_act = 1; m_ti = c + 1; m_td = -1; m_own = gdm;
      if (gdm) begin m_pdm = 0; m_we = m_dmwe; m_addr = m_dma; m_wd = m_dmwd; end
      else     begin m_pif = 0; m_we = 0;      m_addr = m_ifa; m_wd = '0;     end
    end else if (!opif) begin
      m_starve = 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
      c++;
    end
  end

  // Compare process: every output, every cycle, on the falling edge.
  initial begin
    bit e_svc, e_done;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_svc  = in_svc(c);
      e_done = m_act && (c == m_td);
      chk1("cmp_mem_start", mem_start, m_act && (c == m_ti));
      chk1("cmp_busy", busy, e_svc);
      chk1("cmp_if_ready", if_ready, e_done && !m_own);
      chk1("cmp_dm_ready", dm_ready, e_done && m_own);
      chk1("cmp_bus_error", bus_error, e_done && m_err);
      chk1("cmp_owner_data", owner_data, m_own);
      chk32("cmp_if_read_data", if_read_data, m_ifrd);
      chk32("cmp_dm_read_data", dm_read_data, m_dmrd);
      if (e_svc) begin
        chk1("cmp_mem_we", mem_we, m_we);
        chk32("cmp_mem_address", mem_address, m_addr);
        chk32("cmp_mem_write_data", mem_write_data, m_wd);
      end
    end
  end

  // Memory responder: completes lat cycles after each observed mem_start.
  int            lat_lo = 1, lat_hi = 1, due = -1;
  bit            spur = 0, fix_en = 1;
  logic [DW-1:0] fix_d = '0;

  initial forever begin
    @(posedge clk); #1;
    if (mem_start) due = c + int'($urandom_range(lat_hi, lat_lo));
    mem_ready     = (c == due) || (spur && $urandom_range(31, 0) == 0);
    mem_read_data = fix_en ? fix_d : $urandom;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", c);
    $fatal(1, "watchdog");
  end

  task automatic next_cyc();
    @(posedge clk); #1;
    if_start_read = 1'b0;
    dm_start      = 1'b0;
  endtask

  initial begin
    int  s, ndg, ng;
    bit  fetch_seen, fin, seen;

    // Reset state
    repeat (3) next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_mem_start", mem_start, 1'b0);
    chk32("rst_mem_address", mem_address, 32'h0);
    chk32("rst_if_read_data", if_read_data, 32'h0);

    // Fetch only: start@0 -> mem_start@2, ready 3 later -> if_ready@6
    lat_lo = 3; lat_hi = 3; fix_d = 32'h12345678;
    next_cyc(); if_start_read = 1'b1; if_address = 32'h40;
    for (int k = 1; k <= 8; k++) begin
      next_cyc();
      if (k == 2) begin
        chk1("t1_mem_start", mem_start, 1'b1);
        chk32("t1_mem_address", mem_address, 32'h40);
      end
      if (k == 6) begin
        chk1("t1_if_ready", if_ready, 1'b1);
        chk32("t1_if_read_data", if_read_data, 32'h12345678);
      end
    end

    // Simultaneous starts, then data re-requests at each DONE until fetch is forced
    lat_lo = 1; lat_hi = 1; fix_d = 32'h0000_0B0B;
    next_cyc();
    if_start_read = 1'b1; if_address = 32'h80;
    dm_start = 1'b1; dm_we = 1'b0; dm_address = 32'h100;
    ndg = 0; ng = 0; fetch_seen = 0; fin = 0;
    for (int k = 0; k < 200 && !fin; k++) begin
      next_cyc();
      if (mem_start) begin
        if (ng == 0) begin
          chk1("t2_first_owner_data", owner_data, 1'b1);
          chk32("t2_first_address", mem_address, 32'h100);
        end
        if (owner_data) ndg++;
        else if (!fetch_seen) begin
          fetch_seen = 1;
          chk32("t2_data_grants_before_fetch", ndg, 32'd4);
          chk32("t2_fetch_address", mem_address, 32'h80);
        end
        ng++;
      end
      if (dm_ready && !fetch_seen) begin dm_start = 1'b1; dm_address = 32'h100; end
      if (if_ready && fetch_seen) fin = 1;
    end
    chk1("t2_fetch_completed", fin, 1'b1);
    repeat (10) next_cyc();

    // Store: mem_we held through WAIT, dm_read_data unchanged
    lat_lo = 3; lat_hi = 3;
    next_cyc();
    dm_start = 1'b1; dm_we = 1'b1; dm_address = 32'h200; dm_write_data = 32'hDEAD;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      next_cyc();
      if (busy) begin
        chk1("t3_mem_we", mem_we, 1'b1);
        chk32("t3_mem_address", mem_address, 32'h200);
        chk32("t3_mem_write_data", mem_write_data, 32'hDEAD);
      end
      if (dm_ready) begin
        seen = 1;
        chk32("t3_dm_read_data_kept", dm_read_data, 32'h0B0B);
      end
    end
    chk1("t3_dm_ready_seen", seen, 1'b1);
    dm_we = 1'b0;

    // Timeout: memory answers too late -> zero data + bus_error 9 cycles after mem_start
    lat_lo = 12; lat_hi = 12; fix_d = 32'h55;
    next_cyc(); if_start_read = 1'b1; if_address = 32'h300;
    s = -1;
    for (int k = 0; k < 24; k++) begin
      next_cyc();
      if (mem_start && s < 0) s = c;
      if (s >= 0 && c == s + 9) begin
        chk1("t4_if_ready", if_ready, 1'b1);
        chk1("t4_bus_error", bus_error, 1'b1);
        chk32("t4_if_read_data", if_read_data, 32'h0);
      end
      if (s >= 0 && c == s + 13) chk1("t4_late_ready_ignored", if_ready, 1'b0);
    end
    chk1("t4_mem_start_seen", s >= 0, 1'b1);

    // mem_ready on the timeout cycle wins: real data, no error
    lat_lo = 8; lat_hi = 8;
    next_cyc(); if_start_read = 1'b1; if_address = 32'h304;
    s = -1;
    for (int k = 0; k < 16; k++) begin
      next_cyc();
      if (mem_start && s < 0) s = c;
      if (s >= 0 && c == s + 9) begin
        chk1("t5_if_ready", if_ready, 1'b1);
        chk1("t5_bus_error", bus_error, 1'b0);
        chk32("t5_if_read_data", if_read_data, 32'h55);
      end
    end
    chk1("t5_mem_start_seen", s >= 0, 1'b1);

    // Reset in WAIT abandons the access; a fresh request then completes
    lat_lo = 100; lat_hi = 100;
    next_cyc(); if_start_read = 1'b1; if_address = 32'h400;
    for (int k = 0; k < 5; k++) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_if_ready", if_ready, 1'b0);
    chk32("t6_rst_mem_address", mem_address, 32'h0);
    chk32("t6_rst_if_read_data", if_read_data, 32'h0);
    lat_lo = 2; lat_hi = 2; fix_d = 32'h77;
    next_cyc(); if_start_read = 1'b1; if_address = 32'h404;
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      next_cyc();
      if (if_ready) begin
        seen = 1;
        chk32("t6_fresh_if_read_data", if_read_data, 32'h77);
      end
    end
    chk1("t6_fresh_completed", seen, 1'b1);

    // Randomized traffic, latencies straddling the timeout, stray mem_ready, rare resets
    lat_lo = 1; lat_hi = 11; spur = 1; fix_en = 0;
    for (int k = 0; k < 3000; k++) begin
      next_cyc();
      rst = ($urandom_range(399, 0) == 0);
      if ($urandom_range(4, 0) == 0) begin if_start_read = 1'b1; if_address = $urandom; end
      if ($urandom_range(4, 0) == 0) begin
        dm_start = 1'b1; dm_we = 1'($urandom_range(1, 0));
        dm_address = $urandom; dm_write_data = $urandom;
      end
    end
    rst = 1'b0; spur = 0;
    repeat (30) next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
